// File: rtl/bpu_pkg.sv
// Shared branch-predictor types: 2-bit counter encoding, PHT controller FSM
// states and the saturating counter update.
package bpu_pkg;

  typedef enum logic [1:0] {
    STRONGLY_NOT_TAKEN = 2'b00,
    WEAKLY_NOT_TAKEN   = 2'b01,
    WEAKLY_TAKEN       = 2'b10,
    STRONGLY_TAKEN     = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    INIT   = 2'b00,
    IDLE   = 2'b01,
    RMW_RD = 2'b10,
    RMW_WR = 2'b11
  } ctrl_state_t;

  function automatic state_t sat_next(state_t cur, logic taken);
    state_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != STRONGLY_TAKEN) nxt = state_t'(cur + 2'd1);
    end else begin
      if (cur != STRONGLY_NOT_TAKEN) nxt = state_t'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// In-order queue of resolved branch updates {idx, taken}. With PHT_FWD_EN the
// entries are also presented oldest-first so the controller can forward them.
module pht_upd_fifo #(
  parameter int IDX_W = 10,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             push_taken,
  input  logic             pop,
  output logic [IDX_W-1:0] head_idx,
  output logic             head_taken,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
`ifdef PHT_FWD_EN
  ,
  output logic [DEPTH-1:0][IDX_W-1:0] ent_idx,
  output logic [DEPTH-1:0]            ent_taken,
  output logic [DEPTH-1:0]            ent_valid
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [IDX_W:0]   mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign {head_idx, head_taken} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_idx, push_taken};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PHT_FWD_EN
  // Slot k holds the k-th oldest entry, so higher k is younger.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      {ent_idx[k], ent_taken[k]} = mem[rd_ptr + PTR_W'(k)];
      ent_valid[k] = ((PTR_W+1)'(k) < count);
    end
  end
`endif

endmodule

// File: rtl/pht_access_ctrl.sv
// Arbitrates a single-port PHT RAM between fetch lookups and queued counter
// updates (read-modify-write), after an init sweep. PHT_FWD_EN enables update forwarding.
module pht_access_ctrl
  import bpu_pkg::*;
#(
  parameter int PATTERN_NUM_BITS = 10,
  parameter int UPD_FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lookup_valid,
  input  logic [PATTERN_NUM_BITS-1:0] lookup_idx,
  output logic                        lookup_ready,
  output logic                        pred_valid,
  output logic                        pred_taken,
  input  logic                        upd_valid,
  input  logic [PATTERN_NUM_BITS-1:0] upd_idx,
  input  logic                        upd_taken,
  output logic                        upd_ready,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [PATTERN_NUM_BITS-1:0] ram_addr,
  output logic [1:0]                  ram_wdata,
  input  logic [1:0]                  ram_rdata,
  output logic                        init_busy
);

  localparam int CNT_W = $clog2(UPD_FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]            FULL_CNT = CNT_W'(UPD_FIFO_DEPTH);
  localparam logic [PATTERN_NUM_BITS-1:0] LAST_IDX = '1;

  ctrl_state_t                 state;
  logic [PATTERN_NUM_BITS-1:0] sweep_cnt;
  logic [PATTERN_NUM_BITS-1:0] held_idx;
  logic                        held_taken;
  state_t                      held_cnt;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic [CNT_W-1:0]            fifo_count;
  logic [PATTERN_NUM_BITS-1:0] head_idx;
  logic                        head_taken;
  logic                        push;
  logic                        pop;
  logic                        lookup_acc;

`ifdef PHT_FWD_EN
  logic [UPD_FIFO_DEPTH-1:0][PATTERN_NUM_BITS-1:0] ent_idx;
  logic [UPD_FIFO_DEPTH-1:0]                       ent_taken;
  logic [UPD_FIFO_DEPTH-1:0]                       ent_valid;
`endif

  // Lookups yield once the queue is at capacity so updates are never dropped.
  assign lookup_acc   = (state == IDLE) && lookup_valid && (fifo_count != FULL_CNT);
  assign pop          = (state == IDLE) && !lookup_acc && !fifo_empty;
  assign push         = upd_valid && !fifo_full;
  assign lookup_ready = lookup_acc;
  assign upd_ready    = !fifo_full;
  assign init_busy    = (state == INIT);

  pht_upd_fifo #(
    .IDX_W (PATTERN_NUM_BITS),
    .DEPTH (UPD_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_idx   (upd_idx),
    .push_taken (upd_taken),
    .pop        (pop),
    .head_idx   (head_idx),
    .head_taken (head_taken),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
`ifdef PHT_FWD_EN
    ,
    .ent_idx    (ent_idx),
    .ent_taken  (ent_taken),
    .ent_valid  (ent_valid)
`endif
  );

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 2'b00;
    case (state)
      INIT: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = sweep_cnt;
        ram_wdata = STRONGLY_TAKEN;
      end
      IDLE: begin
        if (lookup_acc) begin
          ram_en   = 1'b1;
          ram_addr = lookup_idx;
        end else if (pop) begin
          ram_en   = 1'b1;
          ram_addr = head_idx;
        end
      end
      RMW_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = held_idx;
        ram_wdata = held_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      sweep_cnt  <= '0;
      held_idx   <= '0;
      held_taken <= 1'b0;
      held_cnt   <= STRONGLY_TAKEN;
      pred_valid <= 1'b0;
    end else begin
      pred_valid <= lookup_acc;
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + PATTERN_NUM_BITS'(1);
          if (sweep_cnt == LAST_IDX) state <= IDLE;
        end
        IDLE: begin
          if (pop) begin
            held_idx   <= head_idx;
            held_taken <= head_taken;
            state      <= RMW_RD;
          end
        end
        RMW_RD: begin
          held_cnt <= sat_next(state_t'(ram_rdata), held_taken);
          state    <= RMW_WR;
        end
        RMW_WR: state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

`ifdef PHT_FWD_EN
  logic fwd_hit;
  logic fwd_taken;
  logic fwd_hit_q;
  logic fwd_taken_q;
  logic rmw_active;

  assign rmw_active = (state == RMW_RD) || (state == RMW_WR);

  // Scan oldest to youngest so the last match (youngest update) wins.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_taken = 1'b0;
    if (rmw_active && (held_idx == lookup_idx)) begin
      fwd_hit   = 1'b1;
      fwd_taken = held_taken;
    end
    for (int k = 0; k < UPD_FIFO_DEPTH; k++) begin
      if (ent_valid[k] && (ent_idx[k] == lookup_idx)) begin
        fwd_hit   = 1'b1;
        fwd_taken = ent_taken[k];
      end
    end
    if (push && (upd_idx == lookup_idx)) begin
      fwd_hit   = 1'b1;
      fwd_taken = upd_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit_q   <= 1'b0;
      fwd_taken_q <= 1'b0;
    end else begin
      fwd_hit_q   <= lookup_acc && fwd_hit;
      fwd_taken_q <= fwd_taken;
    end
  end

  assign pred_taken = pred_valid && (fwd_hit_q ? fwd_taken_q : ram_rdata[1]);
`else
  assign pred_taken = pred_valid && ram_rdata[1];
`endif

endmodule

// File: tb/tb_pht_access_ctrl.sv
// Bench for pht_access_ctrl: behavioural RAM, saturating-counter reference model
// and expected-queue scoreboards for predictions and counter write-backs.
module tb_pht_access_ctrl;

  localparam int PNB   = 4;
  localparam int DEPTH = 4;
  localparam int SIZE  = 1 << PNB;
  localparam int WQ_W  = PNB + 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           lookup_valid;
  logic [PNB-1:0] lookup_idx;
  logic           lookup_ready;
  logic           pred_valid;
  logic           pred_taken;
  logic           upd_valid;
  logic [PNB-1:0] upd_idx;
  logic           upd_taken;
  logic           upd_ready;
  logic           ram_en;
  logic           ram_we;
  logic [PNB-1:0] ram_addr;
  logic [1:0]     ram_wdata;
  logic [1:0]     ram_rdata;
  logic           init_busy;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pht_access_ctrl #(
    .PATTERN_NUM_BITS (PNB),
    .UPD_FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_idx   (lookup_idx),
    .lookup_ready (lookup_ready),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx),
    .upd_taken    (upd_taken),
    .upd_ready    (upd_ready),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .init_busy    (init_busy)
  );

  // Single-port RAM: read data appears the cycle after the read.
  logic [1:0] mem [SIZE];
  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = 2'b00;
    ram_rdata = 2'b00;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // ---------------- scoreboard state ----------------
  int             checks = 0;
  int             errors = 0;
  int             ref_cnt [SIZE];
  logic [WQ_W-1:0] wr_q[$];    // {idx, taken, expected counter after write-back}
  logic [0:0]      pred_q[$];
  int             wr_cyc_q[$];
  int             sweep_exp = 0;
  int             cycle = 0;
  logic           busy_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event with nothing expected", name);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    int              c;
    logic            p;
    logic [WQ_W-1:0] e;
    cycle++;
    if (rst) begin
      wr_q.delete();
      pred_q.delete();
      sweep_exp = 0;
      busy_prev = 1'b1;
      for (int i = 0; i < SIZE; i++) ref_cnt[i] = 3;
    end else begin
      if (pred_valid) begin
        if (pred_q.size() == 0) fail_event("pred_unexpected");
        else check("pred_taken", pred_taken, pred_q.pop_front());
      end
      if (upd_valid && upd_ready) begin
        c = ref_cnt[upd_idx];
        if (upd_taken) c = (c == 3) ? 3 : c + 1;
        else           c = (c == 0) ? 0 : c - 1;
        ref_cnt[upd_idx] = c;
        wr_q.push_back({upd_idx, upd_taken, 2'(c)});
      end
      if (lookup_valid && lookup_ready) begin
        p = mem[lookup_idx][1];
`ifdef PHT_FWD_EN
        foreach (wr_q[k]) if (wr_q[k][WQ_W-1:3] == lookup_idx) p = wr_q[k][2];
`endif
        pred_q.push_back(p);
      end
      if (init_busy) begin
        check("sweep_addr", ram_addr, sweep_exp);
        check("sweep_ctl", {ram_en, ram_we, ram_wdata}, 4'b1111);
        check("lookup_ready_init", lookup_ready, 1'b0);
        sweep_exp++;
      end else if (busy_prev) begin
        check("sweep_len", sweep_exp, SIZE);
      end
      busy_prev = init_busy;
      if (!init_busy && ram_en && ram_we) begin
        if (wr_q.size() == 0) fail_event("write_unexpected");
        else begin
          e = wr_q.pop_front();
          check("wr_addr", ram_addr, e[WQ_W-1:3]);
          check("wr_data", ram_wdata, e[1:0]);
        end
        wr_cyc_q.push_back(cycle);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * SIZE; i++) begin
      if (!init_busy) break;
      step();
    end
    check("init_done", init_busy, 1'b0);
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (wr_q.size() == 0) break;
      step();
    end
    check(name, wr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init_busy"}, init_busy, 1'b1);
    check({tag, "_lookup_ready"}, lookup_ready, 1'b0);
    check({tag, "_upd_ready"}, upd_ready, 1'b1);
    check({tag, "_pred_valid"}, pred_valid, 1'b0);
    check({tag, "_pred_taken"}, pred_taken, 1'b0);
    check({tag, "_ram"}, {ram_en, ram_we, ram_wdata, ram_addr}, {1'b1, 1'b1, 2'b11, PNB'(0)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    lookup_valid = 1'b1;
    lookup_idx   = PNB'(5);
    upd_valid    = 1'b0;
    upd_idx      = '0;
    upd_taken    = 1'b0;
    rst          = 1'b1;
    step();
    step();
    check_reset_outputs("rst0");
    rst = 1'b0;

    // Lookup idx 5 held through init; accepted on the first idle cycle.
    wait_idle();
    check("first_lookup_ready", lookup_ready, 1'b1);
    step();
    lookup_valid = 1'b0;
    repeat (3) step();

    // Four not-taken updates to idx 3 with lookups idle.
    wr_cyc_q.delete();
    for (int i = 0; i < 4; i++) begin
      upd_valid = 1'b1;
      upd_idx   = PNB'(3);
      upd_taken = 1'b0;
      step();
    end
    upd_valid = 1'b0;
    wait_drain(40, "drain_idx3");
    check("idx3_writes", wr_cyc_q.size(), 4);
    for (int i = 0; i + 1 < wr_cyc_q.size(); i++)
      check("rmw_spacing", wr_cyc_q[i+1] - wr_cyc_q[i], 3);
    check("ram_idx3", mem[3], 2'b00);
    lookup_valid = 1'b1;
    lookup_idx   = PNB'(3);
    step();
    lookup_valid = 1'b0;
    repeat (2) step();

    // Reset right while a prediction is being presented.
    lookup_valid = 1'b1;
    lookup_idx   = PNB'(5);
    step();
    lookup_valid = 1'b0;
    #1;
    check("pred_before_rst", pred_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst1");
    step();
    step();
    rst = 1'b0;

    // Fill the queue during init, then hold lookups: the drain must win.
    for (int i = 0; i < 4; i++) begin
      upd_valid = 1'b1;
      case (i)
        0: begin upd_idx = PNB'(9);  upd_taken = 1'b1; end
        1: begin upd_idx = PNB'(2);  upd_taken = 1'b0; end
        2: begin upd_idx = PNB'(9);  upd_taken = 1'b0; end
        default: begin upd_idx = PNB'(12); upd_taken = 1'b1; end
      endcase
      step();
    end
    upd_valid = 1'b0;
    #1;
    check("full_upd_ready", upd_ready, 1'b0);
    lookup_valid = 1'b1;
    lookup_idx   = PNB'($urandom_range(0, SIZE - 1));
    wait_idle();
    check("full_lookup_blocked", lookup_ready, 1'b0);
    check("full_pop_read", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, PNB'(9)});
    step();
    check("rmw_rd_lookup_ready", lookup_ready, 1'b0);
    check("upd_ready_after_pop", upd_ready, 1'b1);
    step();
    check("rmw_wr_lookup_ready", lookup_ready, 1'b0);
    check("rmw_wr_we", ram_we, 1'b1);
    step();
    check("lookup_after_rmw", lookup_ready, 1'b1);
    repeat (3) step();
    lookup_valid = 1'b0;

    // Reset during a write-back with two updates still queued.
    for (int i = 0; i < 20; i++) begin
      step();
      if (ram_en && ram_we && !init_busy) break;
    end
    check("found_rmw_wr", ram_en && ram_we && !init_busy, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst2");
    step();
    step();
    rst = 1'b0;
    wait_idle();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      lookup_valid = 1'($urandom_range(0, 1));
      lookup_idx   = PNB'($urandom_range(0, SIZE - 1));
      upd_valid    = ($urandom_range(0, 2) == 0);
      upd_idx      = PNB'($urandom_range(0, 7));
      upd_taken    = 1'($urandom_range(0, 1));
      step();
    end
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
    wait_drain(200, "drain_random");
    repeat (3) step();
    for (int i = 0; i < SIZE; i++) check("final_counter", mem[i], ref_cnt[i]);
    check("pred_q_empty", pred_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
